// File: rtl/vu_pkg.sv
// Shared definitions for the VU meter frame controller: FSM encoding,
// GRB byte placement and colour builders derived from a brightness byte.
package vu_pkg;

  // Frame controller states (fixed encoding kept for legacy compatibility)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_BUSY  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // GRB word layout expected by the strip driver
  localparam int unsigned GRB_G_LSB = 16;
  localparam int unsigned GRB_R_LSB = 8;
  localparam int unsigned GRB_B_LSB = 0;

  localparam logic [7:0]  BRIGHT_DEF = 8'h07;
  localparam logic [23:0] COL_OFF    = 24'h00_0000;

  function automatic logic [23:0] grb(input logic [7:0] g, input logic [7:0] r,
                                      input logic [7:0] b);
    logic [23:0] w;
    w = '0;
    w[GRB_G_LSB +: 8] = g;
    w[GRB_R_LSB +: 8] = r;
    w[GRB_B_LSB +: 8] = b;
    return w;
  endfunction

  function automatic logic [23:0] col_green(input logic [7:0] br);
    return grb(br, 8'h00, 8'h00);
  endfunction

  function automatic logic [23:0] col_yellow(input logic [7:0] br);
    return grb(br, br, 8'h00);
  endfunction

  function automatic logic [23:0] col_red(input logic [7:0] br);
    return grb(8'h00, br, 8'h00);
  endfunction

  function automatic logic [23:0] col_white(input logic [7:0] br);
    return grb(br, br, br);
  endfunction

endpackage

// File: rtl/vu_color_map.sv
// Combinational LED index -> GRB colour: zone-coloured bar plus peak-hold dot.
module vu_color_map
  import vu_pkg::*;
#(
  parameter int unsigned LEDS       = 5,
  parameter int unsigned GREEN_END  = 3,
  parameter int unsigned YELLOW_END = 4,
  parameter logic [7:0]  BRIGHT     = BRIGHT_DEF
) (
  input  logic [7:0]  i_idx,
  input  logic [7:0]  i_bar,
  input  logic [7:0]  i_peak,
  output logic [23:0] o_grb
);

  localparam logic [7:0] N_LEDS = 8'(LEDS);
  localparam logic [7:0] G_END  = 8'(GREEN_END);
  localparam logic [7:0] Y_END  = 8'(YELLOW_END);

  // Bar has priority over the dot; indices past the strip are always dark
  always_comb begin
    o_grb = COL_OFF;
    if (i_idx >= N_LEDS) begin
      o_grb = COL_OFF;
    end else if (i_idx < i_bar) begin
      if (i_idx < G_END)      o_grb = col_green(BRIGHT);
      else if (i_idx < Y_END) o_grb = col_yellow(BRIGHT);
      else                    o_grb = col_red(BRIGHT);
    end else if ((i_peak > i_bar) && (i_idx == (i_peak - 8'd1))) begin
      o_grb = col_white(BRIGHT);
    end
  end

endmodule

// File: rtl/vu_frame_ctrl.sv
// VU meter frame scheduler: max-holds audio levels, computes bar/peak once
// per frame tick and hands each refresh to the strip driver via i_en/o_rdy.
module vu_frame_ctrl
  import vu_pkg::*;
#(
  parameter int unsigned LEDS       = 5,
  parameter int unsigned LEVEL_W    = 8,
  parameter int unsigned CLK_HZ     = 48_000_000,
  parameter int unsigned FRAME_HZ   = 100,
  parameter int unsigned GREEN_END  = 3,
  parameter int unsigned YELLOW_END = 4,
  parameter logic [7:0]  BRIGHT     = BRIGHT_DEF,
  parameter int unsigned PEAK_HOLD  = 50,
  parameter int unsigned EN_TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [LEVEL_W-1:0] i_level,
  input  logic               i_level_vld,
  input  logic [7:0]         i_color_reg,
  output logic [23:0]        o_color_data,
  output logic               o_en,
  input  logic               i_rdy,
  output logic               o_frame_done,
  output logic               o_err
);

  localparam int unsigned DIV    = CLK_HZ / FRAME_HZ;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TO_W   = $clog2(EN_TIMEOUT + 1);
  localparam int unsigned HOLD_W = (PEAK_HOLD > 0) ? $clog2(PEAK_HOLD + 1) : 1;
  localparam int unsigned PROD_W = LEVEL_W + 9;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic [2:0]         state_q, state_d;
  logic [LEVEL_W-1:0] lvl_max_q, lvl_max_d;
  logic [7:0]         bar_q, bar_d;
  logic [7:0]         peak_q, peak_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [PROD_W-1:0]  prod;
  logic [PROD_W-1:0]  scaled;
  logic [7:0]         bar_new;

  // Free-running frame timer; tick marks the last cycle of each frame
  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Level max-hold, bar/peak update at LATCH and the refresh handshake FSM
  always_comb begin
    state_d   = state_q;
    lvl_max_d = lvl_max_q;
    bar_d     = bar_q;
    peak_d    = peak_q;
    hold_d    = hold_q;
    to_d      = to_q;
    en_d      = en_q;
    done_d    = 1'b0;
    err_d     = tick && (state_q != ST_IDLE);

    prod    = PROD_W'(lvl_max_q) * PROD_W'(LEDS + 1);
    scaled  = prod >> LEVEL_W;
    bar_new = (scaled > PROD_W'(LEDS)) ? 8'(LEDS) : scaled[7:0];

    // A sample coinciding with the LATCH clear seeds the next frame's maximum
    if (state_q == ST_LATCH)
      lvl_max_d = i_level_vld ? i_level : '0;
    else if (i_level_vld && (i_level > lvl_max_q))
      lvl_max_d = i_level;

    case (state_q)
      ST_IDLE: begin
        if (tick && i_rdy) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        bar_d = bar_new;
        if (bar_new >= peak_q) begin
          peak_d = bar_new;
          hold_d = HOLD_W'(PEAK_HOLD);
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (peak_q != '0) begin
          peak_d = peak_q - 1'b1;
        end
        en_d    = 1'b1;
        to_d    = '0;
        state_d = ST_START;
      end
      ST_START: begin
        if (!i_rdy) begin
          en_d    = 1'b0;
          state_d = ST_BUSY;
        end else if (to_q == TO_W'(EN_TIMEOUT - 1)) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (i_rdy) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      lvl_max_q <= '0;
      bar_q     <= '0;
      peak_q    <= '0;
      hold_q    <= '0;
      to_q      <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      lvl_max_q <= lvl_max_d;
      bar_q     <= bar_d;
      peak_q    <= peak_d;
      hold_q    <= hold_d;
      to_q      <= to_d;
      en_q      <= en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_en         = en_q;
  assign o_frame_done = done_q;
  assign o_err        = err_q;

  vu_color_map #(
    .LEDS       (LEDS),
    .GREEN_END  (GREEN_END),
    .YELLOW_END (YELLOW_END),
    .BRIGHT     (BRIGHT)
  ) u_color_map (
    .i_idx  (i_color_reg),
    .i_bar  (bar_q),
    .i_peak (peak_q),
    .o_grb  (o_color_data)
  );

endmodule
